// File: rtl/apb_pkg.sv
// apb_pkg
// Shared types and default widths for the APB master bridge slice.
// Contents:
//   APB_ADDR_W_DEF / APB_DATA_W_DEF / APB_TIMEOUT_DEF : default parameter values
//   apb_state_e                                       : bridge FSM state encoding
package apb_pkg;

  localparam int APB_ADDR_W_DEF  = 8;
  localparam int APB_DATA_W_DEF  = 32;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
// Bundles the command/response handshake and the APB bus of the bridge.
// Modports:
//   master : bridge view (drives cmd_ready, rsp_*, PSEL/PENABLE/PWRITE/PADDR/PWDATA)
//   slave  : environment view (drives cmd_*, PRDATA/PREADY/PSLVERR)
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W_DEF,
  parameter int DATA_WIDTH = APB_DATA_W_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
// ACCESS-phase wait timer: a down-counter reloaded by clear and decremented
// while enable is high; expired flags the cycle that would exceed the budget.
// Ports:
//   PCLK, PRESETn : clock, async active-low reset
//   clear         : reload the counter (asserted the cycle before ACCESS)
//   enable        : an ACCESS cycle with PREADY low
//   expired       : enable is high in the TIMEOUT_CYCLES-th waiting cycle
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= LOAD;
    end else if (clear) begin
      count_q <= LOAD;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Terminal count reached while still waiting: this is the last allowed cycle.
  assign expired = enable && (count_q == '0);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns one registered response (rdata + error) per command.
// Ports:
//   PCLK, PRESETn : APB clock, async active-low reset
//   bus (master)  : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata,
//                   rsp_valid/rsp_rdata/rsp_err, APB PSEL/PENABLE/PWRITE/
//                   PADDR/PWDATA/PRDATA/PREADY/PSLVERR
// Build option:
//   APB_MASTER_TIMEOUT_EN : abort an ACCESS phase after TIMEOUT_CYCLES waits
//                           with rsp_err=1; without it the bridge waits forever.
//
// state      | meaning
// APB_IDLE   | cmd_ready high, PSEL low, accept next command
// APB_SETUP  | PSEL=1 PENABLE=0, one cycle
// APB_ACCESS | PSEL=1 PENABLE=1, wait for PREADY (or timeout)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W_DEF,
  parameter int DATA_WIDTH     = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q, state_d;

  logic                  psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q;
  logic                  psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;

  logic accept, done, timeout;

  assign accept = (state_q == APB_IDLE) && bus.cmd_valid;
  assign done   = (state_q == APB_ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  // PREADY gates enable, so a ready slave on the terminal cycle completes normally.
  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state_q == APB_SETUP),
    .enable  ((state_q == APB_ACCESS) && !bus.PREADY),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE:   if (bus.cmd_valid) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (bus.PREADY || timeout) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    psel_d      = (state_d != APB_IDLE);
    penable_d   = (state_d == APB_ACCESS);
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = done || timeout;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
    end
    if (done) begin
      rsp_err_d   = bus.PSLVERR;
      rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
    end else if (timeout) begin
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = (state_q == APB_IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with a RAM-style APB slave model and a
// response scoreboard. Build with APB_MASTER_TIMEOUT_EN to exercise the abort.
module tb_apb_master_bridge;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   rsp_cycles[$];
  int   gaps[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   rsp_count   = 0;

  // Slave model: wait_cfg wait states per ACCESS, err_cfg on the ready cycle,
  // hang suppresses PREADY entirely. Non-ready cycles present junk data/error.
  logic [31:0] mem [256];
  int          wait_cfg = 0;
  int          wcnt     = 0;
  logic        err_cfg  = 1'b0;
  logic        hang     = 1'b0;
  logic        slv_rdy;

  assign slv_rdy     = bus.PSEL && bus.PENABLE && !hang && (wcnt >= wait_cfg);
  assign bus.PREADY  = slv_rdy;
  assign bus.PRDATA  = (slv_rdy && !bus.PWRITE) ? mem[bus.PADDR] : 32'hA5A5_A5A5;
  assign bus.PSLVERR = slv_rdy ? err_cfg : 1'b1;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wcnt <= 0;
    else if (bus.PSEL && bus.PENABLE) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && slv_rdy && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
  end

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: tracks each PSEL window and scores responses at the negedge.
  initial begin : monitor
    exp_t        e;
    int          psel_cnt  = 0;
    int          pen_cnt   = 0;
    int          idle_run  = 0;
    logic        unstable  = 1'b0;
    logic        ready_bad = 1'b0;
    logic        cap_w     = 1'b0;
    logic [7:0]  cap_addr  = '0;
    logic [31:0] cap_wd    = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        psel_cnt = 0; pen_cnt = 0; idle_run = 0; unstable = 1'b0; ready_bad = 1'b0;
      end else begin
        if (bus.PSEL) begin
          if (psel_cnt == 0) begin
            gaps.push_back(idle_run);
            idle_run = 0;
            cap_addr = bus.PADDR; cap_w = bus.PWRITE; cap_wd = bus.PWDATA;
          end else if (bus.PADDR !== cap_addr || bus.PWRITE !== cap_w || bus.PWDATA !== cap_wd) begin
            unstable = 1'b1;
          end
          if (bus.cmd_ready) ready_bad = 1'b1;
          psel_cnt++;
          if (bus.PENABLE) pen_cnt++;
        end else begin
          idle_run++;
        end
        if (bus.rsp_valid) begin
          rsp_count++;
          rsp_cycles.push_back(cyc);
          check("rsp_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_rdata",     bus.rsp_rdata, e.rdata);
            check("rsp_err",       32'(bus.rsp_err), 32'(e.err));
            check("rsp_latency",   32'(cyc - e.acc), 32'(e.lat));
            check("psel_width",    32'(psel_cnt), 32'(e.lat - 1));
            check("penable_width", 32'(pen_cnt), 32'(e.lat - 2));
            check("paddr",         32'(cap_addr), 32'(e.addr));
            check("pwrite",        32'(cap_w), 32'(e.write));
            if (e.write) check("pwdata", cap_wd, e.wdata);
            check("bus_stable",    32'(unstable), 32'd0);
            check("ready_in_xfer", 32'(ready_bad), 32'd0);
          end
          psel_cnt = 0; pen_cnt = 0; unstable = 1'b0; ready_bad = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input bit push, input logic [31:0] exp_rdata, input logic exp_err,
                      input int lat, input bit keep);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    check("cmd_accept", 32'(ok), 32'd1);
    if (ok && push) begin
      e.write = wr; e.addr = addr; e.wdata = wdata;
      e.rdata = exp_rdata; e.err = exp_err; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge PCLK);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge PCLK);
    @(negedge PCLK);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_PSEL"},      32'(bus.PSEL), 32'd0);
    check({pfx, "_PENABLE"},   32'(bus.PENABLE), 32'd0);
    check({pfx, "_PWRITE"},    32'(bus.PWRITE), 32'd0);
    check({pfx, "_PADDR"},     32'(bus.PADDR), 32'd0);
    check({pfx, "_PWDATA"},    bus.PWDATA, 32'd0);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({pfx, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // Reset values
    repeat (3) @(posedge PCLK);
    #1 check_zero("in_reset");
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    check_zero("after_reset");
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Write then read, zero-wait
    send(1'b1, 8'h05, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    send(1'b0, 8'h05, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
    wait_done();

    // Wait states: three PREADY-low ACCESS cycles; junk PSLVERR/PRDATA ignored
    send(1'b1, 8'h10, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    wait_done();
    wait_cfg = 3;
    send(1'b0, 8'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 6, 1'b0);
    wait_done();
    wait_cfg = 0;
    repeat (2) @(negedge PCLK);
    check("rsp_rdata_hold", bus.rsp_rdata, 32'h1234_5678);
    check("rsp_valid_pulse", 32'(bus.rsp_valid), 32'd0);

    // Slave error on a write, then a clean read
    err_cfg = 1'b1;
    send(1'b1, 8'h20, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1, 3, 1'b0);
    wait_done();
    check("rsp_err_hold", 32'(bus.rsp_err), 32'd1);
    err_cfg = 1'b0;
    send(1'b0, 8'h05, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
    wait_done();

    // Back-to-back writes with cmd_valid held, then back-to-back reads
    gaps.delete();
    rsp_cycles.delete();
    for (int i = 0; i < 4; i++)
      send(1'b1, 8'(i), 32'hB0B0_0000 + 32'(i), 1'b1, 32'h0, 1'b0, 3, i < 3);
    wait_done();
    check("b2b_rsp_count", 32'(rsp_cycles.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      check("b2b_rsp_spacing", 32'(i < rsp_cycles.size() ? rsp_cycles[i] - rsp_cycles[i-1] : -1), 32'd3);
    check("b2b_psel_windows", 32'(gaps.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      check("b2b_psel_gap", 32'(i < gaps.size() ? gaps[i] : -1), 32'd1);
    for (int i = 0; i < 4; i++)
      send(1'b0, 8'(i), 32'h0, 1'b1, 32'hB0B0_0000 + 32'(i), 1'b0, 3, i < 3);
    wait_done();

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after 4 ACCESS cycles
    hang = 1'b1;
    send(1'b0, 8'h05, 32'h0, 1'b1, 32'h0, 1'b1, 6, 1'b0);
    wait_done();
    hang = 1'b0;
    send(1'b0, 8'h05, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
    wait_done();
    hang = 1'b1;
    send(1'b0, 8'h07, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
`else
    // Slave never ready: bridge must still be in ACCESS 100 cycles later
    hang = 1'b1;
    rc0 = rsp_count;
    send(1'b0, 8'h07, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    repeat (100) @(negedge PCLK);
    check("hang_PSEL",      32'(bus.PSEL), 32'd1);
    check("hang_PENABLE",   32'(bus.PENABLE), 32'd1);
    check("hang_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("hang_no_rsp",    32'(rsp_count - rc0), 32'd0);
`endif

    // Reset while in ACCESS
    for (int i = 0; i < 20 && !bus.PENABLE; i++) @(negedge PCLK);
    check("pre_reset_access", 32'(bus.PENABLE), 32'd1);
    rc0 = rsp_count;
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) @(negedge PCLK);
    hang    = 1'b0;
    PRESETn = 1'b1;
    #1;
    check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(negedge PCLK);
    check("reset_no_rsp", 32'(rsp_count - rc0), 32'd0);
    send(1'b1, 8'h30, 32'h0BAD_CAFE, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    send(1'b0, 8'h30, 32'h0, 1'b1, 32'h0BAD_CAFE, 1'b0, 3, 1'b0);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
